// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle shared by the initiator and the register-map target.
// Signal names follow the AXI channel names so waveforms read like the protocol.
interface axi4_lite_master_if;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [2:0]  AWPROT;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [2:0]  ARPROT;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARVALID, ARPROT, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARVALID, ARPROT, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one bus transaction,
// one response pulse out carrying read data, response code and latency.
module axi4_lite_master #(
  parameter int CNT_W = 16
) (
  input  logic             ACLK,
  input  logic             ARST,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_write,
  input  logic [31:0]      i_cmd_addr,
  input  logic [31:0]      i_cmd_wdata,
  output logic             o_rsp_valid,
  output logic [31:0]      o_rsp_rdata,
  output logic [1:0]       o_rsp_resp,
  output logic [CNT_W-1:0] o_rsp_cycles,
  output logic [CNT_W-1:0] o_err_count,
  axi4_lite_master_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD      = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q, wvalid_d;
  logic             arvalid_q, arvalid_d;
  logic             bready_q, bready_d;
  logic             rready_q, rready_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]       rsp_resp_q, rsp_resp_d;
  logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept_s;
  logic             aw_done_s;
  logic             w_done_s;

  assign accept_s  = i_cmd_valid & cmd_ready_q;
  // A channel counts as complete once its VALID has dropped or handshakes now.
  assign aw_done_s = ~awvalid_q | axi.AWREADY;
  assign w_done_s  = ~wvalid_q | axi.WREADY;

  // Next-state, latency counter and captured-response logic.
  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;
    rsp_cycles_d = rsp_cycles_q;
    err_cnt_d    = err_cnt_q;

    if (state_q != IDLE) begin
      cnt_d = sat_inc(cnt_q);
    end else if (accept_s) begin
      cnt_d = CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (i_cmd_write) begin
            state_d   = WR;
            awaddr_d  = i_cmd_addr & 32'hFFFF_FFFC;
            wdata_d   = i_cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d  = RD;
            araddr_d = i_cmd_addr & 32'hFFFF_FFFC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        awvalid_d = awvalid_q & ~axi.AWREADY;
        wvalid_d  = wvalid_q & ~axi.WREADY;
        if (aw_done_s && w_done_s) begin
          state_d = WR_RESP;
        end else begin
          state_d = WR;
        end
      end
      WR_RESP: begin
        if (axi.BVALID) begin
          state_d      = RSP;
          rsp_rdata_d  = 32'h0000_0000;
          rsp_resp_d   = axi.BRESP;
          rsp_cycles_d = cnt_d;
        end else begin
          state_d = WR_RESP;
        end
      end
      RD: begin
        if (axi.ARREADY) begin
          state_d = RD_DATA;
        end else begin
          state_d = RD;
        end
      end
      RD_DATA: begin
        if (axi.RVALID) begin
          state_d      = RSP;
          rsp_rdata_d  = axi.RDATA;
          rsp_resp_d   = axi.RRESP;
          rsp_cycles_d = cnt_d;
        end else begin
          state_d = RD_DATA;
        end
      end
      RSP: begin
        state_d = IDLE;
        if (rsp_resp_q != 2'b00) begin
          err_cnt_d = sat_inc(err_cnt_q);
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase

    // Single-bit controls are registered decodes of the upcoming state.
    cmd_ready_d = (state_d == IDLE);
    arvalid_d   = (state_d == RD);
    bready_d    = (state_d == WR_RESP);
    rready_d    = (state_d == RD_DATA);
    rsp_valid_d = (state_d == RSP);
  end

  // State register.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus payload, handshake and response registers.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      awaddr_q     <= 32'h0000_0000;
      araddr_q     <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0000_0000;
      rsp_resp_q   <= 2'b00;
      rsp_cycles_q <= CNT_ZERO;
      err_cnt_q    <= CNT_ZERO;
      cnt_q        <= CNT_ZERO;
    end else begin
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_resp_q   <= rsp_resp_d;
      rsp_cycles_q <= rsp_cycles_d;
      err_cnt_q    <= err_cnt_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_rdata  = rsp_rdata_q;
  assign o_rsp_resp   = rsp_resp_q;
  assign o_rsp_cycles = rsp_cycles_q;
  assign o_err_count  = err_cnt_q;

  assign axi.AWADDR  = awaddr_q;
  assign axi.AWVALID = awvalid_q;
  assign axi.AWPROT  = 3'b000;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = 4'hF;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.ARPROT  = 3'b000;
  assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with a behavioural adder register-map
// target whose per-channel wait states and response codes are set per step.
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        i_cmd_write = 1'b0;
  logic [31:0] i_cmd_addr  = 32'h0;
  logic [31:0] i_cmd_wdata = 32'h0;
  logic        o_cmd_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic [15:0] o_rsp_cycles;
  logic [15:0] o_err_count;

  axi4_lite_master_if bus ();

  axi4_lite_master #(.CNT_W(16)) dut (
    .ACLK         (ACLK),
    .ARST         (ARST),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_write  (i_cmd_write),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_wdata  (i_cmd_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_resp   (o_rsp_resp),
    .o_rsp_cycles (o_rsp_cycles),
    .o_err_count  (o_err_count),
    .axi          (bus)
  );

  always #5 ACLK = ~ACLK;

  int edge_cnt = 0;
  always @(posedge ACLK) edge_cnt <= edge_cnt + 1;

  int passed = 0;
  int total  = 0;
  int acc_cnt = 0;

  // Target configuration, written only by the stimulus.
  int         aw_delay = 0;
  int         w_delay  = 0;
  int         ar_delay = 0;
  int         r_delay  = 0;
  logic [1:0] b_resp_cfg = 2'b00;
  logic [1:0] r_resp_cfg = 2'b00;

  int          aw_wait, w_wait, ar_wait, r_wait, polls;
  logic        aw_got, w_got, b_pending, r_pending, busy, done;
  logic [31:0] s_awaddr, s_wdata, rd_q, r0, r1, r2, leds;
  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0] wr_addr, wr_data;

  assign bus.AWREADY = bus.AWVALID && (aw_wait >= aw_delay);
  assign bus.WREADY  = bus.WVALID && (w_wait >= w_delay);
  assign bus.ARREADY = bus.ARVALID && (ar_wait >= ar_delay);
  assign bus.BVALID  = b_pending;
  assign bus.BRESP   = b_pending ? b_resp_cfg : 2'b00;
  assign bus.RVALID  = r_pending && (r_wait >= r_delay);
  assign bus.RRESP   = r_pending ? r_resp_cfg : 2'b00;
  assign bus.RDATA   = rd_q;

  assign aw_hs   = bus.AWVALID && bus.AWREADY;
  assign w_hs    = bus.WVALID && bus.WREADY;
  assign ar_hs   = bus.ARVALID && bus.ARREADY;
  assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_addr = aw_hs ? bus.AWADDR : s_awaddr;
  assign wr_data = w_hs ? bus.WDATA : s_wdata;

  // Adder register map: a ctrl write with bit0 starts it, the fifth ctrl poll
  // reports done (bit31) and publishes r0+r1 into r2.
  always @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0; polls <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pending <= 1'b0; r_pending <= 1'b0;
      busy <= 1'b0; done <= 1'b0;
      s_awaddr <= 32'h0; s_wdata <= 32'h0; rd_q <= 32'h0;
      r0 <= 32'h0; r1 <= 32'h0; r2 <= 32'h0; leds <= 32'h0;
    end else begin
      if (aw_hs) begin s_awaddr <= bus.AWADDR; aw_got <= 1'b1; aw_wait <= 0; end
      else if (bus.AWVALID) aw_wait <= aw_wait + 1;
      if (w_hs) begin s_wdata <= bus.WDATA; w_got <= 1'b1; w_wait <= 0; end
      else if (bus.WVALID) w_wait <= w_wait + 1;
      if (wr_fire) begin
        case (wr_addr[4:2])
          3'd0: r0 <= wr_data;
          3'd1: r1 <= wr_data;
          3'd2: r2 <= wr_data;
          3'd3: if (wr_data[0]) begin busy <= 1'b1; done <= 1'b0; polls <= 0; end
          3'd4: leds <= wr_data;
          default: ;
        endcase
        b_pending <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bus.BVALID && bus.BREADY) b_pending <= 1'b0;
      if (ar_hs) begin
        r_pending <= 1'b1; r_wait <= 0; ar_wait <= 0;
        case (bus.ARADDR[4:2])
          3'd0: rd_q <= r0;
          3'd1: rd_q <= r1;
          3'd2: rd_q <= r2;
          3'd3: begin
            if (busy && polls == 4) begin
              rd_q <= 32'h8000_0000; r2 <= r0 + r1; busy <= 1'b0; done <= 1'b1;
            end else begin
              rd_q <= done ? 32'h8000_0000 : 32'h0;
              if (busy) polls <= polls + 1;
            end
          end
          3'd4: rd_q <= leds;
          default: rd_q <= 32'h0;
        endcase
      end else if (bus.ARVALID) ar_wait <= ar_wait + 1;
      if (r_pending && !bus.RVALID) r_wait <= r_wait + 1;
      if (bus.RVALID && bus.RREADY) r_pending <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int n;
    @(negedge ACLK);
    i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_wdata = data;
    n = 0;
    while (o_cmd_ready !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    chk("cmd_accept_in_time", 32'(n < 20), 32'd1);
    @(posedge ACLK); #1;
    acc_cnt = edge_cnt;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rdata, output logic [1:0] resp,
                          output logic [15:0] cyc, output int lat);
    int n;
    n = 0;
    do begin @(negedge ACLK); n++; end while (o_rsp_valid !== 1'b1 && n < 300);
    chk("rsp_in_time", 32'(o_rsp_valid), 32'd1);
    rdata = o_rsp_rdata; resp = o_rsp_resp; cyc = o_rsp_cycles;
    lat = edge_cnt - acc_cnt + 1;
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic [1:0] resp,
                        output logic [15:0] cyc, output int lat);
    start_cmd(wr, addr, data);
    wait_rsp(rdata, resp, cyc, lat);
  endtask

  initial begin
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [15:0] cyc;
    int          lat;
    int          zeros;
    logic        done_seen;

    // Reset state
    #1 ARST = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    chk("rst_awvalid", 32'(bus.AWVALID), 32'd0);
    chk("rst_wvalid", 32'(bus.WVALID), 32'd0);
    chk("rst_arvalid", 32'(bus.ARVALID), 32'd0);
    chk("rst_bready_rready", 32'({bus.BREADY, bus.RREADY}), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_err_count", 32'(o_err_count), 32'd0);
    chk("rst_awaddr", bus.AWADDR, 32'h0);
    chk("rst_wdata", bus.WDATA, 32'h0);
    repeat (2) @(negedge ACLK);
    ARST = 1'b0;
    @(negedge ACLK);
    chk("post_rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("awprot", 32'(bus.AWPROT), 32'd0);
    chk("arprot", 32'(bus.ARPROT), 32'd0);
    chk("wstrb", 32'(bus.WSTRB), 32'hF);

    // Zero-wait write r0 <- 5
    start_cmd(1'b1, 32'h00, 32'h5);
    @(negedge ACLK);
    chk("w1_awvalid", 32'(bus.AWVALID), 32'd1);
    chk("w1_wvalid", 32'(bus.WVALID), 32'd1);
    chk("w1_awaddr", bus.AWADDR, 32'h0);
    chk("w1_wdata", bus.WDATA, 32'h5);
    chk("w1_cmd_ready_busy", 32'(o_cmd_ready), 32'd0);
    wait_rsp(rdata, resp, cyc, lat);
    chk("w1_resp", 32'(resp), 32'd0);
    chk("w1_rdata", rdata, 32'h0);
    chk("w1_cycles", 32'(cyc), 32'd3);
    chk("w1_latency", 32'(lat), 32'd3);
    @(negedge ACLK);
    chk("w1_rsp_one_cycle", 32'(o_rsp_valid), 32'd0);
    chk("w1_cycles_held", 32'(o_rsp_cycles), 32'd3);
    chk("w1_ready_after_rsp", 32'(o_cmd_ready), 32'd1);

    // Write 0x0F <- 3, AWREADY held off four cycles, WREADY immediate
    aw_delay = 4;
    start_cmd(1'b1, 32'h0F, 32'h3);
    @(negedge ACLK);
    chk("w2_c1_both_valid", 32'({bus.AWVALID, bus.WVALID}), 32'd3);
    chk("w2_c1_bready", 32'(bus.BREADY), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge ACLK);
      chk("w2_wvalid_dropped", 32'(bus.WVALID), 32'd0);
      chk("w2_awvalid_held", 32'(bus.AWVALID), 32'd1);
      chk("w2_awaddr_stable", bus.AWADDR, 32'h0C);
      chk("w2_bready_early", 32'(bus.BREADY), 32'd0);
    end
    chk("w2_awready_c5", 32'(bus.AWREADY), 32'd1);
    @(negedge ACLK);
    chk("w2_bready_after_aw", 32'(bus.BREADY), 32'd1);
    chk("w2_awvalid_low", 32'(bus.AWVALID), 32'd0);
    wait_rsp(rdata, resp, cyc, lat);
    chk("w2_resp", 32'(resp), 32'd0);
    chk("w2_cycles", 32'(cyc), 32'd7);
    chk("w2_latency", 32'(lat), 32'd7);
    aw_delay = 0;

    // r2 <- 0xC, then read it back with RVALID two cycles late
    do_txn(1'b1, 32'h08, 32'h0000_000C, rdata, resp, cyc, lat);
    chk("w3_resp", 32'(resp), 32'd0);
    r_delay = 2;
    do_txn(1'b0, 32'h08, 32'h0, rdata, resp, cyc, lat);
    chk("r3_rdata", rdata, 32'h0000_000C);
    chk("r3_resp", 32'(resp), 32'd0);
    chk("r3_cycles", 32'(cyc), 32'd5);
    chk("r3_latency", 32'(lat), 32'd5);
    r_delay = 0;

    // Error responses
    b_resp_cfg = 2'b10;
    do_txn(1'b1, 32'h10, 32'hA5, rdata, resp, cyc, lat);
    chk("e1_resp_slverr", 32'(resp), 32'd2);
    @(negedge ACLK);
    chk("e1_err_count", 32'(o_err_count), 32'd1);
    b_resp_cfg = 2'b00;
    r_resp_cfg = 2'b11;
    do_txn(1'b0, 32'h10, 32'h0, rdata, resp, cyc, lat);
    chk("e2_resp_decerr", 32'(resp), 32'd3);
    @(negedge ACLK);
    chk("e2_err_count", 32'(o_err_count), 32'd2);
    r_resp_cfg = 2'b00;

    // Adder sequence
    do_txn(1'b1, 32'h00, 32'd7, rdata, resp, cyc, lat);
    chk("add_w_r0_resp", 32'(resp), 32'd0);
    do_txn(1'b1, 32'h04, 32'd9, rdata, resp, cyc, lat);
    chk("add_w_r1_resp", 32'(resp), 32'd0);
    do_txn(1'b1, 32'h0C, 32'h1, rdata, resp, cyc, lat);
    chk("add_w_ctrl_resp", 32'(resp), 32'd0);
    zeros = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 10 && !done_seen; i++) begin
      do_txn(1'b0, 32'h0C, 32'h0, rdata, resp, cyc, lat);
      chk("add_poll_resp", 32'(resp), 32'd0);
      if (rdata[31]) done_seen = 1'b1;
      else begin
        chk("add_poll_zero", rdata, 32'h0);
        zeros++;
      end
    end
    chk("add_done_seen", 32'(done_seen), 32'd1);
    chk("add_zero_polls", 32'(zeros), 32'd4);
    do_txn(1'b0, 32'h08, 32'h0, rdata, resp, cyc, lat);
    chk("add_r2", rdata, 32'h10);
    chk("add_r2_resp", 32'(resp), 32'd0);
    chk("add_err_unchanged", 32'(o_err_count), 32'd2);

    // Reset while AWVALID waits for AWREADY
    aw_delay = 100;
    w_delay  = 100;
    start_cmd(1'b1, 32'h04, 32'h55);
    repeat (3) @(negedge ACLK);
    chk("ab_awvalid_waiting", 32'(bus.AWVALID), 32'd1);
    #2 ARST = 1'b1;
    #1;
    chk("ab_awvalid_async", 32'(bus.AWVALID), 32'd0);
    chk("ab_wvalid_async", 32'(bus.WVALID), 32'd0);
    chk("ab_cmd_ready", 32'(o_cmd_ready), 32'd0);
    chk("ab_err_cleared", 32'(o_err_count), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge ACLK);
      chk("ab_no_rsp_in_rst", 32'(o_rsp_valid), 32'd0);
    end
    aw_delay = 0;
    w_delay  = 0;
    ARST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      chk("ab_no_rsp_after", 32'(o_rsp_valid), 32'd0);
      chk("ab_ready_after", 32'(o_cmd_ready), 32'd1);
    end
    do_txn(1'b0, 32'h04, 32'h0, rdata, resp, cyc, lat);
    chk("ab_next_rdata", rdata, 32'h0);
    chk("ab_next_resp", 32'(resp), 32'd0);
    chk("ab_next_cycles", 32'(cyc), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns simple command requests into bus transactions.
- Drives the adder register map (r0 0x00, r1 0x04, r2 0x08, ctrl 0x0C, leds 0x10) from a controller or testbench sequencer.
- Returns read data, the response code and measured transaction latency to the requester.

Parameters:
- CNT_W, 16, width of the latency counter and the error counter (both saturating).

Ports:
- ACLK  input  1  clock; everything is sampled on its rising edge.
- ARST  input  1  reset; asynchronous, active-high.
- i_cmd_valid  input  1  command request.
- o_cmd_ready  output  1  block idle; a command is accepted when valid and ready are both high.
- i_cmd_write  input  1  1 = write, 0 = read.
- i_cmd_addr  input  32  byte address.
- i_cmd_wdata  input  32  write data.
- o_rsp_valid  output  1  one-cycle response pulse.
- o_rsp_rdata  output  32  read data; 0 for writes.
- o_rsp_resp  output  2  BRESP or RRESP of the completed transaction.
- o_rsp_cycles  output  CNT_W  cycles from command acceptance to the response pulse.
- o_err_count  output  CNT_W  count of responses not equal to OKAY.
- AWADDR  output  32; AWVALID  output  1; AWREADY  input  1; AWPROT  output  3, fixed 0.
- WDATA  output  32; WSTRB  output  4, fixed 0xF; WVALID  output  1; WREADY  input  1.
- BRESP  input  2; BVALID  input  1; BREADY  output  1.
- ARADDR  output  32; ARVALID  output  1; ARREADY  input  1; ARPROT  output  3, fixed 0.
- RDATA  input  32; RRESP  input  2; RVALID  input  1; RREADY  output  1.

Behaviour:
- Reset (asynchronous, ARST high):
  - State goes to IDLE.
  - All VALID/READY outputs, o_rsp_*, o_err_count and the latency counter are cleared to 0.
  - AWADDR, ARADDR and WDATA are cleared to 0.
  - o_cmd_ready is 0 while ARST is high.
- State machine: IDLE, WR, WR_RESP, RD, RD_DATA, RSP.
- IDLE:
  - o_cmd_ready = 1.
  - On acceptance, the address is latched with bits [1:0] forced to 00 (word addressed), data is latched, and the latency counter is loaded with 1.
  - Next state is WR or RD.
- WR:
  - AWVALID and WVALID both assert in the first WR cycle.
  - Each drops in the cycle after its own handshake; the two handshakes are tracked independently.
  - AW and W may complete in either order or in the same cycle.
  - Once both are complete, go to WR_RESP.
  - BREADY is never high before both handshakes are complete.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, capture BRESP and go to RSP.
- RD:
  - ARVALID = 1 until ARREADY, then go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP and go to RSP.
- RSP:
  - o_rsp_valid = 1 for exactly one cycle, with rdata, resp and cycles valid in that cycle.
  - Return to IDLE.
  - The o_rsp_* data outputs hold their values until the next response.
- Handshake rules:
  - A VALID, once asserted, is never deasserted and its payload never changes until the handshake completes. There is no timeout.
- Latency counter:
  - Increments every cycle outside IDLE and saturates at 2^CNT_W-1.
  - With zero-wait slaves the minimum is 3: write = accept, AW/W handshake, B handshake, then RSP.
- o_err_count:
  - Increments in the RSP cycle when resp != 00, and saturates.
  - Cleared only by reset.
- Commands presented while not in IDLE are ignored (ready is low). A new command can be accepted in the cycle after RSP.
- Reset mid-transaction:
  - Aborts immediately; VALIDs drop and no response is issued.
  - The slave is assumed to be reset by the same ARST.

Test Plan:
- Write 0x00 <- 0x00000005, slave AWREADY/WREADY/BVALID all high every cycle -> AWADDR=0x00 and WDATA=5 in the same cycle, o_rsp_valid 3 cycles after acceptance, resp=00, cycles=3, rdata=0.
- Write addr 0x0F data 0x3; AWREADY delayed 4 cycles, WREADY immediate -> WVALID low from the 2nd WR cycle, AWADDR=0x0C stable until handshake, BREADY rises only after AWREADY, cycles=7.
- Read 0x08, slave returns RDATA=0x0000000C with RVALID 2 cycles after ARREADY -> rsp rdata=0x0000000C, resp=00, cycles=5.
- Write returning BRESP=10 (SLVERR), then read returning RRESP=11 (DECERR) -> resp fields 10 then 11, o_err_count 1 then 2.
- Full adder sequence: write r0=7, r1=9, ctrl=0x1; poll ctrl reads until bit31=1 (model sets it after 4 polls); read r2 -> r2 value 0x10, every response resp=00, exactly 4 ctrl reads observed as 0x0.
- Assert ARST while AWVALID is high, awaiting AWREADY -> AWVALID/WVALID go to 0 asynchronously, no o_rsp_valid; after release o_cmd_ready=1 and the next command completes normally.
